cut_sequencer: RTL and testbench

CUT_SEQUENCER -- requirements
Module: cut_sequencer

---
 rtl/cut_sequencer.sv | 124 ++++++++++++
 tb/tb_cut_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_sequencer.sv
// rtl/cut_sequencer.sv - issues a counted run of cut commands with settle gaps between cuts
// Optional feature: define CUT_TIMEOUT_EN to bound the wait for each cut to end.
module cut_sequencer #(
  parameter int CNT_W          = 8,
  parameter int SETTLE_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_cuts_i,
  input  logic             abort_i,
  output logic             cut_o,
  input  logic             cut_end_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cuts_done_o,
  output logic             error_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] WAIT_END = 3'd2;
  localparam logic [2:0] SETTLE   = 3'd3;
  localparam logic [2:0] FINISH   = 3'd4;
  localparam logic [2:0] ERR      = 3'd5;

  localparam int               SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [2:0]       state;
  logic [CNT_W-1:0] num_cuts_q;
  logic [CNT_W-1:0] cuts_done_q;
  logic [SET_W-1:0] settle_cnt;
  logic             cut_end_q;
  logic             cut_rise;
  logic             last_cut;

`ifdef CUT_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [TO_W-1:0] to_cnt;
  logic            error_q;

  assign error_o = error_q;
`else
  // Constant 0: the timeout length only matters when the timeout is built in.
  assign error_o = (TIMEOUT_CYCLES < 0);
`endif

  assign cut_rise    = cut_end_i & ~cut_end_q;
  assign last_cut    = (cuts_done_q + CNT_W'(1)) == num_cuts_q;
  assign cut_o       = (state == ISSUE) || (state == WAIT_END);
  assign busy_o      = (state == ISSUE) || (state == WAIT_END) || (state == SETTLE) || (state == FINISH);
  assign done_o      = (state == FINISH);
  assign cuts_done_o = cuts_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      num_cuts_q  <= '0;
      cuts_done_q <= '0;
      settle_cnt  <= '0;
      cut_end_q   <= 1'b0;
`ifdef CUT_TIMEOUT_EN
      to_cnt      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      cut_end_q <= cut_end_i;
      // Abort outranks any start or cut-end seen in the same cycle.
      if (abort_i && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, ERR: begin
            if (start_i && !abort_i) begin
              num_cuts_q  <= num_cuts_i;
              cuts_done_q <= '0;
`ifdef CUT_TIMEOUT_EN
              error_q     <= 1'b0;
`endif
              state <= (num_cuts_i == '0) ? FINISH : ISSUE;
            end
          end
          ISSUE: begin
            state <= WAIT_END;
`ifdef CUT_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
          WAIT_END: begin
            if (cut_rise) begin
              cuts_done_q <= (cuts_done_q == '1) ? cuts_done_q : cuts_done_q + CNT_W'(1);
              settle_cnt  <= '0;
              if (last_cut)
                state <= FINISH;
              else
                state <= (SETTLE_CYCLES == 0) ? ISSUE : SETTLE;
            end
`ifdef CUT_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              error_q <= 1'b1;
              state   <= ERR;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST)
              state <= ISSUE;
            else
              settle_cnt <= settle_cnt + SET_W'(1);
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cut_sequencer.sv
// tb/tb_cut_sequencer.sv - self-checking bench for cut_sequencer (timeout case follows CUT_TIMEOUT_EN)
module tb_cut_sequencer;

  localparam int CNT_W  = 8;
  localparam int SETTLE = 5;
  localparam int TMO    = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             cut_end_i = 1'b0;
  logic [CNT_W-1:0] num_cuts_i = '0;
  logic             cut_o;
  logic             busy_o;
  logic             done_o;
  logic             error_o;
  logic [CNT_W-1:0] cuts_done_o;

  int n_chk  = 0;
  int n_fail = 0;
  int dly[256];

  typedef struct {
    int n;
    int d;
    bit level;
    bit spur;
    int exp_pulses;
    int exp_cnt;
    int exp_done;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  cut_sequencer #(.CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_cuts_i(num_cuts_i),
    .abort_i(abort_i), .cut_o(cut_o), .cut_end_i(cut_end_i), .busy_o(busy_o),
    .done_o(done_o), .cuts_done_o(cuts_done_o), .error_o(error_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_trace(input string name, input int got[$], input int want[$]);
    int nbad = 0;
    for (int i = 0; i < got.size() && i < want.size(); i++)
      if (got[i] != want[i]) begin
        if (nbad == 0) $display("  %s first diff at cycle %0d: got %0d want %0d", name, i, got[i], want[i]);
        nbad++;
      end
    chk({name, " mismatching cycles"}, nbad, 0);
  endtask

  // Runs one start..idle sequence while acting as the cut driver, then checks the
  // per-cycle trace against a timeline built from cut delays and the settle length.
  task automatic run_seq(input int n, input bit level, input bit spur,
                         output int pulses, output int dones, output int fin);
    int t_cut[$], t_done[$], t_busy[$], t_cnt[$], t_err[$];
    int e_cut[$], e_done[$], e_busy[$], e_cnt[$], e_err[$];
    int ph = 0, k = 0, cnt = 0, lowc = 0, prev = 0, total = 0;
    pulses = 0;
    dones  = 0;
    @(negedge clk);
    num_cuts_i = n[CNT_W-1:0];
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      t_cut.push_back(int'(cut_o));
      t_done.push_back(int'(done_o));
      t_busy.push_back(int'(busy_o));
      t_cnt.push_back(int'(cuts_done_o));
      t_err.push_back(int'(error_o));
      if (cut_o && prev == 0) pulses++;
      if (done_o) dones++;
      prev = int'(cut_o);
      case (ph)
        0: if (cut_o) begin
             cnt = 1;
             ph  = 1;
           end else begin
             lowc++;
             if (spur && k > 0 && k < n) begin
               if (lowc == 2) begin cut_end_i = 1'b1; start_i = 1'b1; end
               else if (lowc == 3) begin cut_end_i = 1'b0; start_i = 1'b0; end
             end
           end
        1: if (cnt == dly[k]) begin cut_end_i = 1'b1; ph = 2; end
           else cnt++;
        default: if (!level || !cut_o) begin
             cut_end_i = 1'b0;
             ph = 0;
             k++;
             lowc = 0;
           end
      endcase
      if (!busy_o) break;
      @(negedge clk);
    end
    cut_end_i = 1'b0;
    start_i   = 1'b0;
    for (int c = 0; c < n; c++) begin
      for (int j = 0; j <= dly[c]; j++) begin e_cut.push_back(1); e_cnt.push_back(c); end
      if (c < n - 1)
        for (int j = 0; j < SETTLE; j++) begin e_cut.push_back(0); e_cnt.push_back(c + 1); end
    end
    total = e_cut.size();
    e_cut.push_back(0); e_cnt.push_back(n);
    e_cut.push_back(0); e_cnt.push_back(n);
    for (int i = 0; i < total + 2; i++) begin
      e_done.push_back((i == total) ? 1 : 0);
      e_busy.push_back((i <= total) ? 1 : 0);
      e_err.push_back(0);
    end
    chk("trace length", t_cut.size(), total + 2);
    cmp_trace("cut_o", t_cut, e_cut);
    cmp_trace("done_o", t_done, e_done);
    cmp_trace("busy_o", t_busy, e_busy);
    cmp_trace("cuts_done_o", t_cnt, e_cnt);
    cmp_trace("error_o", t_err, e_err);
    fin = t_cnt[t_cnt.size() - 1];
  endtask

  initial begin
    int pulses, dones, fin, seen, hc, prev, got_done, n;
    bit fired, level, spur;

    tbl[0] = '{3, 20, 1'b0, 1'b0, 3, 3, 1};
    tbl[1] = '{0, 1, 1'b0, 1'b0, 0, 0, 1};
    tbl[2] = '{4, 1, 1'b1, 1'b1, 4, 4, 1};
    tbl[3] = '{2, 7, 1'b0, 1'b1, 2, 2, 1};
    tbl[4] = '{255, 1, 1'b0, 1'b0, 255, 255, 1};

    #12;
    chk("reset cut_o", int'(cut_o), 0);
    chk("reset busy_o", int'(busy_o), 0);
    chk("reset done_o", int'(done_o), 0);
    chk("reset cuts_done_o", int'(cuts_done_o), 0);
    chk("reset error_o", int'(error_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < 256; c++) dly[c] = tbl[v].d;
      run_seq(tbl[v].n, tbl[v].level, tbl[v].spur, pulses, dones, fin);
      chk($sformatf("vec%0d cut pulses", v), pulses, tbl[v].exp_pulses);
      chk($sformatf("vec%0d done pulses", v), dones, tbl[v].exp_done);
      chk($sformatf("vec%0d final cuts_done", v), fin, tbl[v].exp_cnt);
    end

    for (int r = 0; r < 6; r++) begin
      n     = int'($urandom_range(0, 6));
      level = 1'($urandom_range(0, 1));
      spur  = 1'($urandom_range(0, 1));
      for (int c = 0; c < 256; c++) dly[c] = int'($urandom_range(1, 8));
      run_seq(n, level, spur, pulses, dones, fin);
      chk($sformatf("rand%0d cut pulses", r), pulses, n);
      chk($sformatf("rand%0d done pulses", r), dones, 1);
      chk($sformatf("rand%0d final cuts_done", r), fin, n);
    end

    // Abort during the 2nd of 4 cuts, coinciding with a cut-end edge.
    @(negedge clk);
    num_cuts_i = 8'd4;
    start_i = 1'b1;
    seen = 0; hc = 0; prev = 0; got_done = 0; fired = 1'b0;
    for (int i = 0; i < 300 && !fired; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) got_done = 1;
      if (cut_o) begin
        if (prev == 0) begin seen++; hc = 0; end
        else hc++;
      end
      prev = int'(cut_o);
      if (cut_o && seen == 1 && hc == 3) cut_end_i = 1'b1;
      if (!cut_o) cut_end_i = 1'b0;
      if (cut_o && seen == 2 && hc == 2) begin abort_i = 1'b1; cut_end_i = 1'b1; fired = 1'b1; end
    end
    chk("abort point reached", int'(fired), 1);
    @(negedge clk);
    abort_i = 1'b0;
    cut_end_i = 1'b0;
    chk("abort cut_o", int'(cut_o), 0);
    chk("abort busy_o", int'(busy_o), 0);
    chk("abort cuts_done_o", int'(cuts_done_o), 1);
    chk("abort done_o", int'(done_o) | got_done, 0);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start with abort busy_o", int'(busy_o), 0);

    // Reset asserted mid-WAIT_END, then a clean run.
    num_cuts_i = 8'd2;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 10 && !cut_o; i++) @(negedge clk);
    chk("pre-reset cut_o", int'(cut_o), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset cut_o", int'(cut_o), 0);
    chk("async reset busy_o", int'(busy_o), 0);
    chk("async reset done_o", int'(done_o), 0);
    chk("async reset cuts_done_o", int'(cuts_done_o), 0);
    chk("async reset error_o", int'(error_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 256; c++) dly[c] = 4;
    run_seq(2, 1'b0, 1'b0, pulses, dones, fin);
    chk("post-reset pulses", pulses, 2);
    chk("post-reset done pulses", dones, 1);

    // Cut driver never responds.
    @(negedge clk);
    num_cuts_i = 8'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("stall cut_o rise", int'(cut_o), 1);
`ifdef CUT_TIMEOUT_EN
    repeat (TMO) @(negedge clk);
    chk("timeout last wait cut_o", int'(cut_o), 1);
    chk("timeout last wait error_o", int'(error_o), 0);
    @(negedge clk);
    chk("timeout cut_o", int'(cut_o), 0);
    chk("timeout error_o", int'(error_o), 1);
    chk("timeout busy_o", int'(busy_o), 0);
    @(negedge clk);
    chk("timeout error sticky", int'(error_o), 1);
    run_seq(1, 1'b0, 1'b0, pulses, dones, fin);
    chk("after timeout pulses", pulses, 1);
`else
    repeat (150) @(negedge clk);
    chk("no-timeout cut_o held", int'(cut_o), 1);
    chk("no-timeout busy_o", int'(busy_o), 1);
    chk("no-timeout error_o", int'(error_o), 0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("no-timeout abort busy_o", int'(busy_o), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
